// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift unit: mode encodings, the per-stage
// sideband record, and small elaboration/bit-order helpers.
package shift_pkg;

  localparam int MODE_W    = 3;
  localparam int AMT_MAX_W = 6;  // enough amount bits for the widest (64-bit) datapath

  localparam logic [MODE_W-1:0] SHIFT_SLL = 3'd0;
  localparam logic [MODE_W-1:0] SHIFT_SRL = 3'd1;
  localparam logic [MODE_W-1:0] SHIFT_SRA = 3'd2;
  localparam logic [MODE_W-1:0] SHIFT_ROL = 3'd3;
  localparam logic [MODE_W-1:0] SHIFT_ROR = 3'd4;

  typedef struct packed {
    logic [MODE_W-1:0]    mode;
    logic                 fill;
    logic                 oor;
    logic [AMT_MAX_W-1:0] amt;
  } side_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [63:0] bit_reverse(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

  function automatic logic is_rotate(input logic [MODE_W-1:0] mode);
    return (mode == SHIFT_ROL) || (mode == SHIFT_ROR);
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One pipeline stage: a group of right-shift barrel levels followed by the
// valid/data/sideband register, which only loads when the stage advances.
module shift_pipe_stage
  import shift_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 5,
  parameter int FIRST_LVL = 0,
  parameter int NUM_LVL   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  side_t            in_side,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output side_t            out_side,
  output logic [TAG_W-1:0] out_tag
);

  logic [WIDTH-1:0] lvl_data;
  logic             rot;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  side_t            side_d, side_q;
  logic [TAG_W-1:0] tag_d, tag_q;

  // NOTE: blocking assignments here are intentional: each level consumes the
  // previous level's result within the same evaluation.
  always_comb begin
    rot      = is_rotate(in_side.mode);
    lvl_data = in_data;
    for (int k = FIRST_LVL; k < FIRST_LVL + NUM_LVL; k++) begin
      if (in_side.amt[k]) begin
        if (rot)
          lvl_data = (lvl_data >> (1 << k)) | (lvl_data << (WIDTH - (1 << k)));
        else if (in_side.fill)
          lvl_data = (lvl_data >> (1 << k)) | ~({WIDTH{1'b1}} >> (1 << k));
        else
          lvl_data = lvl_data >> (1 << k);
      end
    end
  end

  // NOTE: every signal gets its hold value first so no path can infer a latch.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    side_d  = side_q;
    tag_d   = tag_q;
    if (adv) begin
      valid_d = in_valid;
      data_d  = lvl_data;
      side_d  = in_side;
      tag_d   = in_tag;
    end
  end

  // NOTE: the datapath registers are reset too, because the outputs driven from
  // them must read as zero while the pipe is in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      side_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      side_q  <= side_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_side  = side_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined shift/rotate unit: entry pre-processing, STAGES barrel-level stages
// with valid/ready backpressure, and exit post-processing.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int AMT_W  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int L   = clog2(WIDTH);
  localparam int PER = (L + STAGES - 1) / STAGES;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  dat [STAGES];
  side_t             sd  [STAGES];
  logic [TAG_W-1:0]  tg  [STAGES];

  logic [WIDTH-1:0]  ent_data;
  side_t             ent_side;
  logic              ent_left;
  logic              ent_shift;
  side_t             last_side;
  logic [WIDTH-1:0]  exit_data;
  logic [AMT_MAX_W-1:0] unused_amt;

  // Left modes run through the right shifter on bit-reversed data.
  always_comb begin
    ent_left  = (in_mode == SHIFT_SLL) || (in_mode == SHIFT_ROL);
    ent_shift = (in_mode == SHIFT_SLL) || (in_mode == SHIFT_SRL) || (in_mode == SHIFT_SRA);
    ent_side      = '0;
    ent_side.mode = in_mode;
    ent_side.fill = (in_mode == SHIFT_SRA) & in_data[WIDTH-1];
    ent_side.oor  = ent_shift & ((in_amt >> L) != '0);
    if (in_mode <= SHIFT_ROR) ent_side.amt[L-1:0] = in_amt[L-1:0];
    ent_data = ent_left ? WIDTH'(bit_reverse(64'(in_data), WIDTH)) : in_data;
  end

  // Stage i advances when empty or when the stage after it advances.
  always_comb begin
    logic nxt;
    nxt = out_ready;
    adv = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      adv[s] = !vld[s] | nxt;
      nxt    = adv[s];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int FIRST = s * PER;
    localparam int NUM   = (FIRST >= L) ? 0 : (((L - FIRST) < PER) ? (L - FIRST) : PER);

    logic             prev_valid;
    logic [WIDTH-1:0] prev_data;
    side_t            prev_side;
    logic [TAG_W-1:0] prev_tag;

    if (s == 0) begin : g_first
      assign prev_valid = in_valid;
      assign prev_data  = ent_data;
      assign prev_side  = ent_side;
      assign prev_tag   = in_tag;
    end else begin : g_next
      assign prev_valid = vld[s-1];
      assign prev_data  = dat[s-1];
      assign prev_side  = sd[s-1];
      assign prev_tag   = tg[s-1];
    end

    shift_pipe_stage #(
      .WIDTH     (WIDTH),
      .TAG_W     (TAG_W),
      .FIRST_LVL (FIRST),
      .NUM_LVL   (NUM)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv[s]),
      .in_valid  (prev_valid),
      .in_data   (prev_data),
      .in_side   (prev_side),
      .in_tag    (prev_tag),
      .out_valid (vld[s]),
      .out_data  (dat[s]),
      .out_side  (sd[s]),
      .out_tag   (tg[s])
    );
  end

  // Out-of-range shifts saturate to the fill pattern; left modes un-reverse.
  always_comb begin
    last_side = sd[STAGES-1];
    exit_data = last_side.oor ? {WIDTH{last_side.fill}} : dat[STAGES-1];
    if ((last_side.mode == SHIFT_SLL) || (last_side.mode == SHIFT_ROL))
      out_data = WIDTH'(bit_reverse(64'(exit_data), WIDTH));
    else
      out_data = exit_data;
  end

  assign unused_amt = last_side.amt;
  assign out_valid  = vld[STAGES-1];
  assign out_tag    = tg[STAGES-1];
  assign in_ready   = adv[0];

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: a 32-bit/2-stage instance for the directed
// scenarios and a 64-bit/3-stage instance for back-to-back traffic.
module tb_shift_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, 2-stage instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, in_amt, out_data;
  logic [2:0]  in_mode;
  logic [4:0]  in_tag, out_tag;

  // 64-bit, 3-stage instance
  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
  logic [63:0] in_data_w, out_data_w;
  logic [31:0] in_amt_w;
  logic [2:0]  in_mode_w;
  logic [4:0]  in_tag_w, out_tag_w;

  int errors = 0;
  int checks = 0;

  shift_pipe #(.WIDTH(32), .AMT_W(32), .STAGES(2), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  shift_pipe #(.WIDTH(64), .AMT_W(32), .STAGES(3), .TAG_W(5)) dut_w (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_w), .in_ready(in_ready_w), .in_data(in_data_w), .in_amt(in_amt_w),
    .in_mode(in_mode_w), .in_tag(in_tag_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w), .out_tag(out_tag_w)
  );

  // Bit-by-bit reference for the random traffic.
  function automatic logic [63:0] model(input logic [2:0] m, input logic [63:0] a,
                                        input logic [31:0] amt, input int w);
    longint unsigned am;
    int sh, rs;
    logic [63:0] r;
    am = amt;
    sh = (am < longint'(w)) ? int'(am) : w;
    rs = int'(am % longint'(w));
    r  = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        3'd0:    r[i] = (i >= sh) ? a[i-sh] : 1'b0;
        3'd1:    r[i] = (i + sh < w) ? a[i+sh] : 1'b0;
        3'd2:    r[i] = (i + sh < w) ? a[i+sh] : a[w-1];
        3'd3:    r[i] = a[(i - rs + w) % w];
        3'd4:    r[i] = a[(i + rs) % w];
        default: r[i] = a[i];
      endcase
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request on the 32-bit unit and returns its result and latency.
  task automatic send32(input logic [2:0] m, input logic [31:0] d, input logic [31:0] a,
                        input logic [4:0] t, output logic [31:0] res,
                        output logic [4:0] rtag, output int lat);
    int waitc;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = m;
    in_data   = d;
    in_amt    = a;
    in_tag    = t;
    #1;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    tick();
    in_valid = 1'b0;
    lat = (waitc < 20) ? 1 : -100;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    res  = out_data;
    rtag = out_tag;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
    checks++; if (out_tag !== 5'd0) begin errors++; $display("FAIL reset_out_tag: got %0d expected 0", out_tag); end
    rst = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_sra_latency();
    logic [31:0] r;
    logic [4:0]  t;
    int lat;
    send32(3'd2, 32'h8000_0000, 32'd4, 5'd3, r, t, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sra_latency: got %0d expected 2", lat); end
    checks++; if (r !== 32'hF800_0000) begin errors++; $display("FAIL sra_data: got %h expected f8000000", r); end
    checks++; if (t !== 5'd3) begin errors++; $display("FAIL sra_tag: got %0d expected 3", t); end
  endtask

  typedef struct {
    logic [2:0]  m;
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] e;
  } vec_t;

  task automatic test_modes_ranges();
    vec_t v [14];
    logic [31:0] r;
    logic [4:0]  t;
    int lat;
    v[0]  = '{3'd1, 32'hF000_0000, 32'd40,         32'h0000_0000};
    v[1]  = '{3'd2, 32'h8000_0001, 32'd32,         32'hFFFF_FFFF};
    v[2]  = '{3'd3, 32'h8000_0001, 32'd33,         32'h0000_0003};
    v[3]  = '{3'd4, 32'h0000_0001, 32'd1,          32'h8000_0000};
    v[4]  = '{3'd0, 32'h0000_0001, 32'd31,         32'h8000_0000};
    v[5]  = '{3'd0, 32'h0000_0001, 32'd32,         32'h0000_0000};
    v[6]  = '{3'd2, 32'h7FFF_FFFF, 32'd100,        32'h0000_0000};
    v[7]  = '{3'd1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000};
    v[8]  = '{3'd4, 32'hA5A5_A5A5, 32'd0,          32'hA5A5_A5A5};
    v[9]  = '{3'd6, 32'h1234_5678, 32'd5,          32'h1234_5678};
    v[10] = '{3'd2, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF};
    v[11] = '{3'd3, 32'h1234_5678, 32'd4,          32'h2345_6781};
    v[12] = '{3'd1, 32'h8000_0000, 32'd31,         32'h0000_0001};
    v[13] = '{3'd2, 32'hC000_0000, 32'd1,          32'hE000_0000};
    for (int i = 0; i < 14; i++) begin
      send32(v[i].m, v[i].d, v[i].a, 5'(i + 1), r, t, lat);
      checks++;
      if (r !== v[i].e || t !== 5'(i + 1) || lat !== 2) begin
        errors++;
        $display("FAIL vector_%0d: got data=%h tag=%0d lat=%0d expected data=%h tag=%0d lat=2",
                 i, r, t, lat, v[i].e, i + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got_d [3];
    logic [4:0]  got_t [3];
    logic [31:0] exp_d [3];
    logic [4:0]  exp_t [3];
    int n;
    logic took;
    exp_d[0] = 32'h0123_4567; exp_t[0] = 5'd10;
    exp_d[1] = 32'h0000_FF00; exp_t[1] = 5'd11;
    exp_d[2] = 32'h0000_000F; exp_t[2] = 5'd12;
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 3'd1; in_data = 32'h1234_5678; in_amt = 32'd4; in_tag = 5'd10;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_first: got %b expected 1", in_ready); end
    tick();
    in_mode = 3'd0; in_data = 32'h0000_00FF; in_amt = 32'd8; in_tag = 5'd11;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_second: got %b expected 1", in_ready); end
    tick();
    in_mode = 3'd4; in_data = 32'h0000_00F0; in_amt = 32'd4; in_tag = 5'd12;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== exp_d[0] || out_tag !== exp_t[0]) begin
      errors++; $display("FAIL bp_head: got v=%b d=%h t=%0d expected v=1 d=%h t=%0d", out_valid, out_data, out_tag, exp_d[0], exp_t[0]);
    end
    repeat (3) tick();
    checks++; if (out_data !== exp_d[0] || out_tag !== exp_t[0]) begin
      errors++; $display("FAIL bp_hold: got d=%h t=%0d expected d=%h t=%0d", out_data, out_tag, exp_d[0], exp_t[0]);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      took = in_valid && in_ready;
      if (out_valid) begin
        if (n < 3) begin got_d[n] = out_data; got_t[n] = out_tag; end
        n++;
      end
      tick();
      if (took) in_valid = 1'b0;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= n || got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
        errors++;
        $display("FAIL bp_order_%0d: got d=%h t=%0d expected d=%h t=%0d", i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] r;
    logic [4:0]  t;
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 3'd1; in_data = 32'h0000_00FF; in_amt = 32'd4; in_tag = 5'd7;
    #1;
    tick();
    in_mode = 3'd0; in_data = 32'h0000_0001; in_amt = 32'd1; in_tag = 5'd8;
    #1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_000F || out_tag !== 5'd7) begin
      errors++; $display("FAIL mid_pre: got v=%b d=%h t=%0d expected v=1 d=0000000f t=7", out_valid, out_data, out_tag);
    end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0) begin
      errors++; $display("FAIL mid_reset: got v=%b d=%h t=%0d expected v=0 d=00000000 t=0", out_valid, out_data, out_tag);
    end
    #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_replay_%0d: got %b expected 0", c, out_valid); end
    end
    send32(3'd4, 32'h0000_0003, 32'd1, 5'd20, r, t, lat);
    checks++; if (r !== 32'h8000_0001 || t !== 5'd20 || lat !== 2) begin
      errors++; $display("FAIL mid_after: got d=%h t=%0d lat=%0d expected d=80000001 t=20 lat=2", r, t, lat);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 40;
    logic [63:0] exp_q [$];
    logic [4:0]  tag_q [$];
    logic [63:0] e;
    logic [4:0]  et;
    int sent, recv, first_out, sel;
    sent = 0; recv = 0; first_out = -1;
    out_ready_w = 1'b1;
    for (int c = 0; c < N + 20 && recv < N; c++) begin
      if (sent < N) begin
        in_valid_w = 1'b1;
        in_mode_w  = 3'($urandom_range(0, 7));
        in_data_w  = {$urandom(), $urandom()};
        sel = $urandom_range(0, 9);
        if (sel == 0)      in_amt_w = $urandom();
        else if (sel == 1) in_amt_w = 32'd64;
        else               in_amt_w = 32'($urandom_range(0, 63));
        in_tag_w = 5'(sent);
      end else begin
        in_valid_w = 1'b0;
      end
      #1;
      if (in_valid_w) begin
        checks++;
        if (in_ready_w !== 1'b1) begin
          errors++; $display("FAIL b2b_ready_cycle_%0d: got %b expected 1", c, in_ready_w);
        end else begin
          exp_q.push_back(model(in_mode_w, in_data_w, in_amt_w, 64));
          tag_q.push_back(in_tag_w);
          sent++;
        end
      end
      if (out_valid_w) begin
        if (first_out < 0) first_out = c;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious: got d=%h expected no result", out_data_w);
        end else begin
          e = exp_q.pop_front();
          et = tag_q.pop_front();
          if (out_data_w !== e || out_tag_w !== et) begin
            errors++; $display("FAIL b2b_result_%0d: got d=%h t=%0d expected d=%h t=%0d", recv, out_data_w, out_tag_w, e, et);
          end
        end
        recv++;
      end
      tick();
    end
    in_valid_w = 1'b0;
    checks++; if (first_out !== 3) begin errors++; $display("FAIL b2b_latency: got %0d expected 3", first_out); end
    checks++; if (recv !== N) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", recv, N); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_amt = '0; in_mode = '0; in_tag = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b1; in_data_w = '0; in_amt_w = '0; in_mode_w = '0; in_tag_w = '0;
    #1;
    test_reset();
    test_sra_latency();
    test_modes_ranges();
    test_backpressure();
    test_reset_midstream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
